// File: rtl/clk_freq_meter.sv
// rtl/clk_freq_meter.sv - counts synchronized clk_in rising edges per gate window and tracks frequency lock.
// Optional phase-width glitch check is compiled in with CLK_FREQ_METER_GLITCH_CHECK_EN.
module clk_freq_meter #(
  parameter int GATE_CYCLES  = 1000,
  parameter int EXPECTED     = 125,
  parameter int TOLERANCE    = 2,
  parameter int LOCK_WINDOWS = 3,
  parameter int COUNT_W      = 16,
  parameter int MIN_PHASE    = 2
) (
  input  logic               clk_ref,
  input  logic               rst,
  input  logic               clk_in,
  input  logic               enable,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid,
  output logic               locked,
  output logic               lost,
  output logic               glitch
);

  localparam int GATE_W   = $clog2(GATE_CYCLES);
  localparam int STREAK_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [GATE_W-1:0]     GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0]    CNT_MAX     = '1;
  localparam logic [STREAK_W-1:0]   STREAK_FULL = STREAK_W'(LOCK_WINDOWS);
  localparam logic signed [COUNT_W:0] EXP_S     = (COUNT_W + 1)'(EXPECTED);
  localparam logic signed [COUNT_W:0] TOL_S     = (COUNT_W + 1)'(TOLERANCE);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_t;

  state_t                 state;
  logic                   s1, s2, s3;
  logic                   settle_cnt;
  logic [GATE_W-1:0]      gate_cnt;
  logic [COUNT_W-1:0]     edge_cnt;
  logic [STREAK_W-1:0]    streak;

  logic                   rise;
  logic [COUNT_W-1:0]     edge_next;
  logic signed [COUNT_W:0] diff;
  logic signed [COUNT_W:0] abs_diff;
  logic                   good;
  logic [STREAK_W-1:0]    streak_inc;

  assign rise       = s2 & ~s3;
  assign edge_next  = (rise && edge_cnt != CNT_MAX) ? edge_cnt + COUNT_W'(1) : edge_cnt;
  assign diff       = $signed({1'b0, edge_next}) - EXP_S;
  assign abs_diff   = (diff < 0) ? -diff : diff;
  assign good       = (abs_diff <= TOL_S);
  assign streak_inc = (streak == STREAK_FULL) ? STREAK_FULL : streak + STREAK_W'(1);

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= 1'b0;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      streak      <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      lost        <= 1'b0;
      if (!enable) begin
        // Abort silently: partial window dropped, last count_out retained.
        state      <= IDLE;
        settle_cnt <= 1'b0;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        streak     <= '0;
        locked     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= SETTLE;
            settle_cnt <= 1'b0;
          end
          SETTLE: begin
            if (settle_cnt) begin
              state    <= MEASURE;
              gate_cnt <= '0;
              edge_cnt <= '0;
            end else begin
              settle_cnt <= 1'b1;
            end
          end
          MEASURE: begin
            if (gate_cnt == GATE_LAST) begin
              gate_cnt    <= '0;
              edge_cnt    <= '0;
              count_out   <= edge_next;
              count_valid <= 1'b1;
              if (good) begin
                streak <= streak_inc;
                locked <= (streak_inc == STREAK_FULL);
              end else begin
                streak <= '0;
                locked <= 1'b0;
                lost   <= locked;
              end
            end else begin
              gate_cnt <= gate_cnt + GATE_W'(1);
              edge_cnt <= edge_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CLK_FREQ_METER_GLITCH_CHECK_EN
  localparam int PH_W = $clog2(MIN_PHASE + 1) + 1;
  localparam logic [PH_W-1:0] PH_MAX = '1;
  localparam logic [PH_W-1:0] PH_MIN = PH_W'(MIN_PHASE);

  logic [PH_W-1:0] phase_cnt;

  // phase_cnt holds the length of the s2 phase that ends when s2 and s3 differ.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      phase_cnt <= '0;
      glitch    <= 1'b0;
    end else begin
      if (s2 != s3)
        phase_cnt <= PH_W'(1);
      else if (phase_cnt != PH_MAX)
        phase_cnt <= phase_cnt + PH_W'(1);
      if (!enable)
        glitch <= 1'b0;
      else if (state == MEASURE && s2 != s3 && phase_cnt < PH_MIN)
        glitch <= 1'b1;
    end
  end
`else
  assign glitch = 1'b0;
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb/tb_clk_freq_meter.sv - randomized self-checking bench for clk_freq_meter.
// Expected counts come from an edge log of the driven clk_in shifted by synchronizer latency.
module tb_clk_freq_meter;
  localparam int GATE  = 1000;
  localparam int EXPV  = 125;
  localparam int TOL   = 2;
  localparam int LOCKW = 3;
`ifdef CLK_FREQ_METER_GLITCH_CHECK_EN
  localparam bit GLITCH_ON = 1'b1;
`else
  localparam bit GLITCH_ON = 1'b0;
`endif

  logic        clk_ref = 1'b0, rst = 1'b1, clk_in = 1'b0, enable = 1'b0;
  logic        clk_in2 = 1'b0, enable2 = 1'b0;
  logic [15:0] count_out;
  logic        count_valid, locked, lost, glitch;
  logic [7:0]  count_out2;
  logic        count_valid2, locked2, lost2, glitch2;

  int checks = 0, errors = 0, cyc = 0;
  int half = 4, ph_left = 4;
  bit rand_mode = 0, pulse_req = 0, base = 0;
  bit h1 [0:65535];
  bit h2 [0:65535];
  int m_streak = 0, last_e = 0;
  bit m_locked = 0;

  clk_freq_meter dut (
    .clk_ref(clk_ref), .rst(rst), .clk_in(clk_in), .enable(enable),
    .count_out(count_out), .count_valid(count_valid), .locked(locked),
    .lost(lost), .glitch(glitch)
  );

  clk_freq_meter #(.COUNT_W(8)) dut2 (
    .clk_ref(clk_ref), .rst(rst), .clk_in(clk_in2), .enable(enable2),
    .count_out(count_out2), .count_valid(count_valid2), .locked(locked2),
    .lost(lost2), .glitch(glitch2)
  );

  initial forever #5 clk_ref = ~clk_ref;

  // clk_in generator: fixed or random half-periods, optional 1-cycle pulse inside a low phase.
  initial forever begin
    @(posedge clk_ref);
    cyc++;
    #1;
    if (ph_left <= 1) begin
      base    = ~base;
      ph_left = rand_mode ? int'($urandom_range(3, 5)) : half;
    end else begin
      ph_left--;
    end
    if (pulse_req && !base && ph_left == 2) begin
      clk_in    = 1'b1;
      pulse_req = 0;
    end else begin
      clk_in = base;
    end
    clk_in2 = ~clk_in2;
    if (cyc < 65536) begin
      h1[cyc] = clk_in;
      h2[cyc] = clk_in2;
    end
  end

  // Window reported at cycle t covers rises driven in cycles t-GATE-2 .. t-3.
  function automatic int exp_count(input int t, input bit two);
    int c = 0;
    for (int n = t - GATE - 2; n <= t - 3; n++) begin
      if (n >= 1 && n < 65536) begin
        if (two ? (h2[n] && !h2[n-1]) : (h1[n] && !h1[n-1])) c++;
      end
    end
    return c;
  endfunction

  function automatic int sat(input int c, input int w);
    int mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_window(input int c, output bit lk, output bit ls);
    int d = c - EXPV;
    if (d < 0) d = -d;
    ls = 0;
    if (d <= TOL) begin
      if (m_streak < LOCKW) m_streak++;
    end else begin
      ls = m_locked;
      m_streak = 0;
    end
    m_locked = (m_streak == LOCKW);
    lk = m_locked;
  endtask

  task automatic wait_valid(input bit two, input int budget, output int at, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_ref);
      if ((two ? count_valid2 : count_valid) === 1'b1) begin
        ok = 1;
        break;
      end
    end
    at = cyc;
  endtask

  task automatic run_until_locked(output bit ok);
    int t;
    bit lk, ls, got;
    ok = 0;
    for (int k = 0; k < 8; k++) begin
      wait_valid(0, 1100, t, got);
      if (!got) return;
      last_e = sat(exp_count(t, 0), 16);
      model_window(last_e, lk, ls);
      if (m_locked) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; enable2 = 0;
    repeat (4) @(posedge clk_ref);
    @(negedge clk_ref);
    checks++;
    if (count_out !== 16'd0 || count_valid !== 1'b0 || locked !== 1'b0 || lost !== 1'b0 || glitch !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got cnt=%0d v=%b lk=%b ls=%b g=%b want all 0", count_out, count_valid, locked, lost, glitch);
    end
    checks++;
    if (count_out2 !== 8'd0 || count_valid2 !== 1'b0 || locked2 !== 1'b0 || lost2 !== 1'b0 || glitch2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs2 got cnt=%0d v=%b lk=%b ls=%b g=%b want all 0", count_out2, count_valid2, locked2, lost2, glitch2);
    end
    @(posedge clk_ref); #2 rst = 0;
  endtask

  task automatic test_lock();
    int t, prev, e;
    bit ok, lk, ls;
    half = 4;
    @(posedge clk_ref); #2 enable = 1; prev = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_valid(0, 1100, t, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL lock_timeout window %0d", k); break; end
      checks++;
      if (t - prev !== ((k == 0) ? GATE + 3 : GATE)) begin
        errors++; $display("FAIL lock_spacing got %0d want %0d", t - prev, (k == 0) ? GATE + 3 : GATE);
      end
      e = sat(exp_count(t, 0), 16);
      model_window(e, lk, ls);
      checks++;
      if (count_out !== 16'(e)) begin errors++; $display("FAIL lock_count got %0d want %0d", count_out, e); end
      checks++;
      if (count_out !== 16'd125) begin errors++; $display("FAIL lock_count_nominal got %0d want 125", count_out); end
      checks++;
      if (locked !== lk || lost !== ls) begin
        errors++; $display("FAIL lock_flags got lk=%b ls=%b want lk=%b ls=%b", locked, lost, lk, ls);
      end
      checks++;
      if (locked !== (k >= 2)) begin errors++; $display("FAIL lock_third_window k=%0d got %b want %b", k, locked, k >= 2); end
      prev = t;
    end
  endtask

  task automatic test_period6();
    int t, e;
    bit ok, lk, ls;
    half = 3;
    for (int k = 0; k < 3; k++) begin
      wait_valid(0, 1100, t, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL p6_timeout window %0d", k); break; end
      e = sat(exp_count(t, 0), 16);
      model_window(e, lk, ls);
      checks++;
      if (count_out !== 16'(e)) begin errors++; $display("FAIL p6_count got %0d want %0d", count_out, e); end
      checks++;
      if (locked !== lk || lost !== ls) begin
        errors++; $display("FAIL p6_flags got lk=%b ls=%b want lk=%b ls=%b", locked, lost, lk, ls);
      end
      if (k >= 1) begin
        checks++;
        if (count_out !== 16'd166 && count_out !== 16'd167) begin
          errors++; $display("FAIL p6_range got %0d want 166 or 167", count_out);
        end
      end
      @(negedge clk_ref);
      checks++;
      if (lost !== 1'b0) begin errors++; $display("FAIL p6_lost_width got %b want 0", lost); end
    end
  endtask

  task automatic test_abort();
    int t, prev, e;
    bit ok, lk, ls, saw_v, saw_l;
    half = 4;
    run_until_locked(ok);
    checks++;
    if (!ok || locked !== 1'b1) begin errors++; $display("FAIL abort_prelock got ok=%b lk=%b want 1 1", ok, locked); end
    repeat (500) @(posedge clk_ref);
    #2 enable = 0;
    saw_v = 0; saw_l = 0;
    repeat (1100) begin
      @(negedge clk_ref);
      if (count_valid) saw_v = 1;
      if (lost) saw_l = 1;
    end
    m_streak = 0; m_locked = 0;
    checks++;
    if (saw_v !== 1'b0) begin errors++; $display("FAIL abort_no_valid got %b want 0", saw_v); end
    checks++;
    if (saw_l !== 1'b0) begin errors++; $display("FAIL abort_no_lost got %b want 0", saw_l); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL abort_unlock got %b want 0", locked); end
    checks++;
    if (count_out !== 16'(last_e)) begin errors++; $display("FAIL abort_hold got %0d want %0d", count_out, last_e); end
    @(posedge clk_ref); #2 enable = 1; prev = cyc;
    wait_valid(0, 1100, t, ok);
    checks++;
    if (!ok || t - prev !== GATE + 3) begin
      errors++; $display("FAIL abort_reenable_latency got ok=%b dt=%0d want %0d", ok, t - prev, GATE + 3);
    end
    e = sat(exp_count(t, 0), 16);
    model_window(e, lk, ls);
    checks++;
    if (count_out !== 16'(e) || locked !== lk) begin
      errors++; $display("FAIL abort_first_window got cnt=%0d lk=%b want cnt=%0d lk=%b", count_out, locked, e, lk);
    end
  endtask

  task automatic test_random();
    int t, prev, e;
    bit ok, lk, ls;
    rand_mode = 1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_valid(0, 1100, t, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_timeout window %0d", k); break; end
      if (k > 0) begin
        checks++;
        if (t - prev !== GATE) begin errors++; $display("FAIL rand_spacing got %0d want %0d", t - prev, GATE); end
      end
      e = sat(exp_count(t, 0), 16);
      model_window(e, lk, ls);
      checks++;
      if (count_out !== 16'(e)) begin errors++; $display("FAIL rand_count got %0d want %0d", count_out, e); end
      checks++;
      if (locked !== lk || lost !== ls) begin
        errors++; $display("FAIL rand_flags got lk=%b ls=%b want lk=%b ls=%b", locked, lost, lk, ls);
      end
      prev = t;
    end
    rand_mode = 0; half = 4;
  endtask

  task automatic test_glitch();
    repeat (40) @(posedge clk_ref);
    @(negedge clk_ref);
    checks++;
    if (glitch !== 1'b0) begin errors++; $display("FAIL glitch_clean got %b want 0", glitch); end
    pulse_req = 1;
    repeat (30) @(negedge clk_ref);
    checks++;
    if (glitch !== GLITCH_ON) begin errors++; $display("FAIL glitch_set got %b want %b", glitch, GLITCH_ON); end
    repeat (200) @(negedge clk_ref);
    checks++;
    if (glitch !== GLITCH_ON) begin errors++; $display("FAIL glitch_held got %b want %b", glitch, GLITCH_ON); end
    @(posedge clk_ref); #2 enable = 0;
    @(posedge clk_ref); @(negedge clk_ref);
    m_streak = 0; m_locked = 0;
    checks++;
    if (glitch !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL glitch_clear got g=%b lk=%b want 0 0", glitch, locked);
    end
  endtask

  task automatic test_reset_mid();
    int t, prev, e;
    bit ok, lk, ls;
    @(posedge clk_ref); #2 enable = 1;
    run_until_locked(ok);
    checks++;
    if (!ok || locked !== 1'b1) begin errors++; $display("FAIL rstmid_prelock got ok=%b lk=%b want 1 1", ok, locked); end
    repeat (300) @(posedge clk_ref);
    #2 rst = 1;
    @(posedge clk_ref); @(negedge clk_ref);
    checks++;
    if (count_out !== 16'd0 || count_valid !== 1'b0 || locked !== 1'b0 || lost !== 1'b0 || glitch !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got cnt=%0d v=%b lk=%b ls=%b g=%b want all 0", count_out, count_valid, locked, lost, glitch);
    end
    @(posedge clk_ref); #2 rst = 0; prev = cyc;
    m_streak = 0; m_locked = 0;
    wait_valid(0, 1100, t, ok);
    checks++;
    if (!ok || t - prev !== GATE + 3) begin
      errors++; $display("FAIL rstmid_restart got ok=%b dt=%0d want %0d", ok, t - prev, GATE + 3);
    end
    e = sat(exp_count(t, 0), 16);
    model_window(e, lk, ls);
    checks++;
    if (count_out !== 16'(e) || locked !== lk) begin
      errors++; $display("FAIL rstmid_window got cnt=%0d lk=%b want cnt=%0d lk=%b", count_out, locked, e, lk);
    end
  endtask

  task automatic test_saturate();
    int t, prev, e;
    bit ok;
    @(posedge clk_ref); #2 enable2 = 1; prev = cyc;
    for (int k = 0; k < 2; k++) begin
      wait_valid(1, 1100, t, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sat_timeout window %0d", k); break; end
      checks++;
      if (t - prev !== ((k == 0) ? GATE + 3 : GATE)) begin
        errors++; $display("FAIL sat_spacing got %0d want %0d", t - prev, (k == 0) ? GATE + 3 : GATE);
      end
      e = sat(exp_count(t, 1), 8);
      checks++;
      if (count_out2 !== 8'(e) || count_out2 !== 8'd255) begin
        errors++; $display("FAIL sat_count got %0d want %0d (255)", count_out2, e);
      end
      checks++;
      if (locked2 !== 1'b0) begin errors++; $display("FAIL sat_locked got %b want 0", locked2); end
      prev = t;
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_period6();
    test_abort();
    test_random();
    test_glitch();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
